seg7_onehot_encoder: RTL and testbench
======================================

SEG7_ONEHOT_ENCODER -- requirements
Module: seg7_onehot_encoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive matching samples required before a pattern is accepted.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port seg_in  input  7  segment pattern {a,b,c,d,e,f,g}, active-high.
REQ-005 SHALL have port in_valid  input  1  seg_in is meaningful this cycle.
REQ-006 SHALL have port out_ready  input  1  consumer accepts the presented result.
REQ-007 SHALL have port onehot_out  output  16  one-hot digit; bit k set for hex digit k.
REQ-008 SHALL have port code_out  output  4  binary digit value.
REQ-009 SHALL have port blank_out  output  1  accepted pattern was all-off.
REQ-010 SHALL have port err_out  output  1  accepted pattern was illegal.
REQ-011 SHALL have port out_valid  output  1  result registers hold an accepted result.
REQ-012 SHALL have port err_count  output  8  saturating count of illegal accepted patterns.

Function
REQ-013 SHALL decode these legal patterns (hex of seg_in) to digits 0..F: 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47.
REQ-014 SHALL implement FSM states IDLE, SETTLE, PRESENT.
REQ-015 IDLE: on edge with in_valid=1, capture seg_in into sample register, stability count=1; go SETTLE, or go PRESENT directly if STABLE_CYCLES=1.
REQ-016 SETTLE, in_valid=1, seg_in==sample: count+1; when count reaches STABLE_CYCLES, load result registers, go PRESENT.
REQ-017 SETTLE, in_valid=1, seg_in!=sample: recapture seg_in, count=1, stay SETTLE.
REQ-018 SETTLE, in_valid=0: count=0, return IDLE; no result produced.
REQ-019 Latency: stable pattern with in_valid held from edge 1 SHALL assert out_valid after edge STABLE_CYCLES.
REQ-020 On entry to PRESENT: out_valid=1; onehot_out, code_out, blank_out, err_out SHALL stay constant while out_valid=1.
REQ-021 Legal pattern: onehot_out = 1<<digit, code_out=digit, blank_out=0, err_out=0.
REQ-022 Pattern 00: onehot_out=0, code_out=0, blank_out=1, err_out=0.
REQ-023 Any other pattern: onehot_out=0, code_out=0, blank_out=0, err_out=1; err_count increments, saturating at FF.
REQ-024 PRESENT: seg_in and in_valid ignored; on edge with out_ready=1, out_valid=0 and go IDLE; result registers keep last value.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 Back-to-back: a new capture SHALL NOT occur on the edge that completes the handshake; earliest capture is the following edge.
REQ-027 Exactly one handshake per accepted pattern; a held pattern yields a new result each IDLE->PRESENT pass.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, count=0, sample=00, onehot_out=0, code_out=0, blank_out=0, err_out=0, out_valid=0, err_count=0.
REQ-029 Reset asserted in any state, including PRESENT with out_valid=1, SHALL discard the pending result without handshake.
REQ-030 First capture SHALL occur on the first rising edge after rst deasserts with in_valid=1.

Verification
REQ-031 STABLE_CYCLES=4, seg_in=6D, in_valid held, out_ready=0 -> out_valid=1 after 4th edge, onehot_out=0004, code_out=2; held until out_ready=1.
REQ-032 seg_in=47 for 2 cycles then 4F held -> no result for 47; after 4 edges of 4F, onehot_out=4000, code_out=E.
REQ-033 seg_in=01 held until accepted, handshake, repeated 300 times -> err_out=1, onehot_out=0 each time; err_count saturates at FF.
REQ-034 seg_in=00 held -> blank_out=1, err_out=0, onehot_out=0; in_valid dropped at count 3 instead -> FSM returns IDLE, out_valid stays 0.
REQ-035 rst pulsed mid-SETTLE and in PRESENT -> all outputs 0 asynchronously; next result requires a full STABLE_CYCLES.
REQ-036 Sweep all 128 seg_in values, STABLE_CYCLES=1 -> 16 legal digits, 1 blank, 111 errors; out_valid after first edge each time.

Source files
------------

// File: rtl/seg7_onehot_encoder.sv
// Debounces a 7-segment pattern and encodes it to one-hot and binary hex digits,
// with blank/illegal flags, a valid/ready result handshake and a saturating error counter.
module seg7_onehot_encoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic [15:0] onehot_out,
  output logic [3:0]  code_out,
  output logic        blank_out,
  output logic        err_out,
  output logic        out_valid,
  output logic [7:0]  err_count
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

  state_t     r_state;
  logic [7:0] r_count;
  logic [6:0] r_sample;

  logic       w_legal;
  logic [3:0] w_digit;
  logic       w_blank;
  logic       w_match;
  logic [7:0] w_count_nxt;
  logic       w_accept;

  always_comb begin
    w_legal = 1'b1;
    w_digit = '0;
    case (seg_in)
      7'h7E: w_digit = 4'h0;
      7'h30: w_digit = 4'h1;
      7'h6D: w_digit = 4'h2;
      7'h79: w_digit = 4'h3;
      7'h33: w_digit = 4'h4;
      7'h5B: w_digit = 4'h5;
      7'h5F: w_digit = 4'h6;
      7'h70: w_digit = 4'h7;
      7'h7F: w_digit = 4'h8;
      7'h7B: w_digit = 4'h9;
      7'h77: w_digit = 4'hA;
      7'h1F: w_digit = 4'hB;
      7'h4E: w_digit = 4'hC;
      7'h3D: w_digit = 4'hD;
      7'h4F: w_digit = 4'hE;
      7'h47: w_digit = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_blank     = (seg_in == '0);
  assign w_match     = (seg_in == r_sample);
  assign w_count_nxt = r_count + 8'd1;

  // The accepted pattern always equals seg_in on the accepting edge, so decode seg_in directly.
  assign w_accept = in_valid &&
                    (((r_state == IDLE) && (STABLE == 8'd1)) ||
                     ((r_state == SETTLE) && w_match && (w_count_nxt == STABLE)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_sample   <= '0;
      onehot_out <= '0;
      code_out   <= '0;
      blank_out  <= 1'b0;
      err_out    <= 1'b0;
      out_valid  <= 1'b0;
      err_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sample <= seg_in;
            r_count  <= 8'd1;
            r_state  <= (STABLE == 8'd1) ? PRESENT : SETTLE;
          end
        end
        SETTLE: begin
          if (!in_valid) begin
            r_count <= '0;
            r_state <= IDLE;
          end else if (w_match) begin
            r_count <= w_count_nxt;
            if (w_count_nxt == STABLE) r_state <= PRESENT;
          end else begin
            r_sample <= seg_in;
            r_count  <= 8'd1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_count   <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        out_valid  <= 1'b1;
        onehot_out <= w_legal ? (16'b1 << w_digit) : '0;
        code_out   <= w_legal ? w_digit : '0;
        blank_out  <= w_blank;
        err_out    <= !w_legal && !w_blank;
        if (!w_legal && !w_blank && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_onehot_encoder.sv
// Randomised and directed bench for seg7_onehot_encoder: two instances (STABLE_CYCLES 4 and 1)
// checked every cycle against a run-length behavioural model.
module tb_seg7_onehot_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic        in_valid;
  logic        out_ready;

  logic [15:0] a_oh, b_oh;
  logic [3:0]  a_code, b_code;
  logic        a_blank, b_blank, a_err, b_err, a_ov, b_ov;
  logic [7:0]  a_ec, b_ec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_onehot_encoder #(.STABLE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .seg_in(seg_in), .in_valid(in_valid), .out_ready(out_ready),
    .onehot_out(a_oh), .code_out(a_code), .blank_out(a_blank), .err_out(a_err),
    .out_valid(a_ov), .err_count(a_ec));

  seg7_onehot_encoder #(.STABLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .seg_in(seg_in), .in_valid(in_valid), .out_ready(out_ready),
    .onehot_out(b_oh), .code_out(b_code), .blank_out(b_blank), .err_out(b_err),
    .out_valid(b_ov), .err_count(b_ec));

  logic [6:0] PAT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int SC [2] = '{4, 1};

  // Model: a result is presented once a run of identical valid samples reaches SC.
  bit         mv    [2];
  int         run   [2];
  logic [6:0] last  [2];
  logic [15:0] moh  [2];
  logic [3:0] mcode [2];
  bit         mblank[2];
  bit         merr  [2];
  int         mec   [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; run[i] = 0; last[i] = '0; moh[i] = '0; mcode[i] = '0;
      mblank[i] = 0; merr[i] = 0; mec[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int found;
    if (mv[i]) begin
      if (out_ready) mv[i] = 0;
    end else if (in_valid) begin
      if (run[i] > 0 && seg_in == last[i]) run[i]++;
      else begin last[i] = seg_in; run[i] = 1; end
      if (run[i] >= SC[i]) begin
        run[i] = 0; mv[i] = 1;
        moh[i] = '0; mcode[i] = '0; mblank[i] = 0; merr[i] = 0;
        found = -1;
        for (int k = 0; k < 16; k++) if (PAT[k] == seg_in) found = k;
        if (found >= 0) begin
          moh[i] = 16'(1 << found);
          mcode[i] = 4'(found);
        end else if (seg_in == 7'h00) mblank[i] = 1;
        else begin
          merr[i] = 1;
          if (mec[i] < 255) mec[i]++;
        end
      end
    end else run[i] = 0;
  endtask

  task automatic cmp_inst(input int i, input string p, input logic [15:0] oh, input logic [3:0] cd,
                          input logic bl, input logic er, input logic ov, input logic [7:0] ec);
    chk({p, ".out_valid"}, 32'(ov), 32'(mv[i]));
    chk({p, ".onehot_out"}, 32'(oh), 32'(moh[i]));
    chk({p, ".code_out"}, 32'(cd), 32'(mcode[i]));
    chk({p, ".blank_out"}, 32'(bl), 32'(mblank[i]));
    chk({p, ".err_out"}, 32'(er), 32'(merr[i]));
    chk({p, ".err_count"}, 32'(ec), 32'(mec[i]));
  endtask

  task automatic compare_all();
    cmp_inst(0, "A", a_oh, a_code, a_blank, a_err, a_ov, a_ec);
    cmp_inst(1, "B", b_oh, b_code, b_blank, b_err, b_ov, b_ec);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous pulse between edges; outputs must clear before any clock edge.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("rst_async_ov", 32'(a_ov), 32'd0);
    chk("rst_async_oh", 32'(a_oh), 32'd0);
    #1 rst = 1'b0;
  endtask

  task automatic wait_a_valid(output int n);
    n = 0;
    while (!a_ov && n < 40) begin tick(); n++; end
    if (!a_ov) chk("wait_a_valid_timeout", 32'(a_ov), 32'd1);
  endtask

  initial begin
    int n, n_leg, n_blank, n_err;
    rst = 1'b1; seg_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_ov", 32'(a_ov), 32'd0);
    chk("reset_ec", 32'(a_ec), 32'd0);
    rst = 1'b0;

    // 6D stable -> digit 2 after the 4th edge, held until out_ready
    seg_in = 7'h6D; in_valid = 1'b1;
    repeat (3) tick();
    chk("lat_before4", 32'(a_ov), 32'd0);
    tick();
    chk("lat_at4_ov", 32'(a_ov), 32'd1);
    chk("lat_at4_oh", 32'(a_oh), 32'h0004);
    chk("lat_at4_code", 32'(a_code), 32'd2);
    seg_in = 7'h30;
    repeat (3) tick();
    chk("hold_oh", 32'(a_oh), 32'h0004);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("handshake_ov", 32'(a_ov), 32'd0);
    chk("keep_oh", 32'(a_oh), 32'h0004);
    out_ready = 1'b0;

    // 47 for two cycles, then 4F -> E
    in_valid = 1'b1; seg_in = 7'h47;
    repeat (2) tick();
    seg_in = 7'h4F;
    repeat (3) tick();
    chk("glitch_no_res", 32'(a_ov), 32'd0);
    tick();
    chk("glitch_oh", 32'(a_oh), 32'h4000);
    chk("glitch_code", 32'(a_code), 32'hE);
    in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;

    // blank, then drop in_valid at count 3
    in_valid = 1'b1; seg_in = 7'h00;
    wait_a_valid(n);
    chk("blank_bl", 32'(a_blank), 32'd1);
    chk("blank_err", 32'(a_err), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
    in_valid = 1'b1; repeat (3) tick();
    in_valid = 1'b0; repeat (3) tick();
    chk("drop_ov", 32'(a_ov), 32'd0);

    // reset mid-SETTLE and in PRESENT, full latency afterwards
    in_valid = 1'b1; seg_in = 7'h79;
    repeat (2) tick();
    pulse_rst();
    wait_a_valid(n);
    chk("rst_settle_lat", 32'(n), 32'd4);
    pulse_rst();
    chk("rst_present_ov", 32'(a_ov), 32'd0);
    wait_a_valid(n);
    chk("rst_present_lat", 32'(n), 32'd4);
    chk("rst_present_code", 32'(a_code), 32'd3);
    in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 300 illegal patterns saturate the error counter
    for (int r = 0; r < 300; r++) begin
      in_valid = 1'b1; seg_in = 7'h01; out_ready = 1'b0;
      wait_a_valid(n);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("sat_ec", 32'(a_ec), 32'hFF);
    chk("sat_err", 32'(a_err), 32'd1);
    chk("sat_oh", 32'(a_oh), 32'd0);

    // sweep all patterns on the single-cycle instance
    pulse_rst();
    n_leg = 0; n_blank = 0; n_err = 0;
    for (int v = 0; v < 128; v++) begin
      in_valid = 1'b1; seg_in = 7'(v); out_ready = 1'b0;
      tick();
      if (b_ov !== 1'b1) chk("sweep_ov", 32'(b_ov), 32'd1);
      if (b_err) n_err++;
      else if (b_blank) n_blank++;
      else if (b_oh != 0) n_leg++;
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
    end
    chk("sweep_legal", 32'(n_leg), 32'd16);
    chk("sweep_blank", 32'(n_blank), 32'd1);
    chk("sweep_err", 32'(n_err), 32'd111);
    chk("sweep_ec", 32'(b_ec), 32'd111);

    // randomised traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0)
        seg_in = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127))
                                             : PAT[$urandom_range(0, 15)];
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
      if ($urandom_range(0, 299) == 0) pulse_rst();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
